// File: rtl/mxint_pkg.sv
// Shared MXInt helpers: the signed exponent range and the S2 mantissa shift
// used by the MXInt operators.
package mxint_pkg;

    localparam int DEF_EXP_WIDTH = 32'sd8;

    // Most negative representable shared exponent for a given exponent width
    function automatic int exp_min(input int exp_width);
        return -(32'sd1 << (exp_width - 32'sd1));
    endfunction

    // Most positive representable shared exponent for a given exponent width
    function automatic int exp_max(input int exp_width);
        return (32'sd1 << (exp_width - 32'sd1)) - 32'sd1;
    endfunction

    localparam int EXP_MIN = exp_min(DEF_EXP_WIDTH);
    localparam int EXP_MAX = exp_max(DEF_EXP_WIDTH);

    // Shared exponent from the leading-one index, clamped low to the exponent range
    function automatic int shared_exp(input int p, input int in_frac, input int exp_width);
        int e;
        e = p - in_frac + 32'sd1;
        return (e < exp_min(exp_width)) ? exp_min(exp_width) : e;
    endfunction

    // Right-shift amount (negative means shift left) that places the block's
    // leading magnitude bit just under the mantissa sign bit
    function automatic int mant_shift(input int p, input int in_frac, input int out_man,
                                      input int exp_width);
        return shared_exp(p, in_frac, exp_width) + in_frac - 32'sd1 - (out_man - 32'sd2);
    endfunction

endpackage

// File: rtl/mxint_lod.sv
// Leading-one detector: index of the highest set bit plus an all-zero flag.
// Purely combinational.
module mxint_lod #(
    parameter int WIDTH     = 16,
    parameter int IDX_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     vec,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 zero
);

    // Scan upward so the highest set bit is the last one to win
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = vec[i] ? IDX_WIDTH'(i) : idx;
        end
    end

    assign zero = ~|vec;

endmodule

// File: rtl/fixed_to_mxint.sv
// Fixed-point block to MXInt quantiser. Two pipeline stages:
//   S1 registers the block and the leading-one index of its OR-reduced magnitude.
//   S2 derives the shared exponent and shifts every element into a mantissa.
// rst asserts asynchronously; its release is expected to be synchronous to clk.
module fixed_to_mxint
    import mxint_pkg::*;
#(
    parameter int IN_WIDTH      = 16,
    parameter int IN_FRAC_WIDTH = 8,
    parameter int OUT_MAN_WIDTH = 8,
    parameter int OUT_EXP_WIDTH = 8,
    parameter int BLOCK_SIZE    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_WIDTH-1:0]      data_in [BLOCK_SIZE],
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    output logic [OUT_MAN_WIDTH-1:0] mdata_out [BLOCK_SIZE],
    output logic [OUT_EXP_WIDTH-1:0] edata_out,
    output logic                     data_out_valid,
    input  logic                     data_out_ready
);

    localparam int P_WIDTH   = $clog2(IN_WIDTH);
    localparam int EXT_WIDTH = IN_WIDTH + OUT_MAN_WIDTH;
    localparam logic [OUT_EXP_WIDTH-1:0] EMIN_BITS = OUT_EXP_WIDTH'(exp_min(OUT_EXP_WIDTH));

    // The largest possible exponent must be representable
    if (IN_WIDTH - IN_FRAC_WIDTH - 1 > exp_max(OUT_EXP_WIDTH)) begin : g_exp_range_check
        $error("fixed_to_mxint: OUT_EXP_WIDTH too small for IN_WIDTH/IN_FRAC_WIDTH");
    end

    logic [IN_WIDTH-1:0]      or_mag_s;
    logic [P_WIDTH-1:0]       lod_idx_s;
    logic                     lod_zero_s;
    logic                     s2_load_s;
    logic                     s1_move_s;
    logic                     accept_s;

    logic                     s1_valid_r;
    logic [IN_WIDTH-1:0]      s1_data_r [BLOCK_SIZE];
    logic [P_WIDTH-1:0]       s1_p_r;
    logic                     s1_zero_r;

    int                       exp_s;
    int                       shift_s;
    int                       shamt_s;
    logic signed [EXT_WIDTH-1:0] ext_s [BLOCK_SIZE];
    logic [OUT_MAN_WIDTH-1:0] man_next_s [BLOCK_SIZE];
    logic [OUT_EXP_WIDTH-1:0] exp_next_s;

    // OR of every element's magnitude bits (value XOR its replicated sign), so
    // negatives are measured as ~x; the top bit of the result is always 0
    always_comb begin
        or_mag_s = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            or_mag_s = or_mag_s | (data_in[i] ^ {IN_WIDTH{data_in[i][IN_WIDTH-1]}});
        end
    end

    mxint_lod #(
        .WIDTH     (IN_WIDTH),
        .IDX_WIDTH (P_WIDTH)
    ) u_lod (
        .vec  (or_mag_s),
        .idx  (lod_idx_s),
        .zero (lod_zero_s)
    );

    // Handshake: S2 frees when empty or draining, S1 frees when empty or moving on
    assign s2_load_s     = !data_out_valid || data_out_ready;
    assign s1_move_s     = s1_valid_r && s2_load_s;
    assign data_in_ready = !s1_valid_r || s2_load_s;
    assign accept_s      = data_in_valid && data_in_ready;

    // S1 register: capture the block and its leading-one index on accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_p_r     <= '0;
            s1_zero_r  <= 1'b1;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                s1_data_r[i] <= '0;
            end
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_p_r     <= lod_idx_s;
            s1_zero_r  <= lod_zero_s;
            s1_data_r  <= data_in;
        end else if (s1_move_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // S2 datapath: shared exponent and per-element arithmetic shift with floor rounding
    always_comb begin
        exp_s   = shared_exp(int'(s1_p_r), IN_FRAC_WIDTH, OUT_EXP_WIDTH);
        shift_s = mant_shift(int'(s1_p_r), IN_FRAC_WIDTH, OUT_MAN_WIDTH, OUT_EXP_WIDTH);
        shamt_s = (shift_s >= 32'sd0) ? shift_s : -shift_s;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            ext_s[i] = {{OUT_MAN_WIDTH{s1_data_r[i][IN_WIDTH-1]}}, s1_data_r[i]};
            if (s1_zero_r) begin
                man_next_s[i] = '0;
            end else if (shift_s >= 32'sd0) begin
                man_next_s[i] = OUT_MAN_WIDTH'(ext_s[i] >>> shamt_s);
            end else begin
                man_next_s[i] = OUT_MAN_WIDTH'(ext_s[i] << shamt_s);
            end
        end
        exp_next_s = s1_zero_r ? EMIN_BITS : OUT_EXP_WIDTH'(exp_s);
    end

    // S2 register: output stage, holds stable while the consumer stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_valid <= 1'b0;
            edata_out      <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                mdata_out[i] <= '0;
            end
        end else if (s2_load_s) begin
            data_out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                edata_out <= exp_next_s;
                mdata_out <= man_next_s;
            end
        end
    end

endmodule

// File: tb/tb_fixed_to_mxint.sv
// Self-checking bench for fixed_to_mxint (BLOCK_SIZE=4).
module tb_fixed_to_mxint;

    localparam int BS = 4;

    typedef struct packed {
        logic [7:0]          e;
        logic [BS-1:0][7:0]  m;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data_in [BS];
    logic        data_in_valid = 1'b0;
    logic        data_in_ready;
    logic [7:0]  mdata_out [BS];
    logic [7:0]  edata_out;
    logic        data_out_valid;
    logic        data_out_ready = 1'b1;

    int nassert = 0;
    int nfail   = 0;

    logic [15:0] dir_in [5][BS] = '{
        '{16'h0100, 16'hFF00, 16'h0080, 16'h0000},
        '{16'hFF00, 16'h0000, 16'h0000, 16'h0000},
        '{16'h0001, 16'h0000, 16'h0000, 16'h0000},
        '{16'h0103, 16'hFEFD, 16'h0000, 16'h0000},
        '{16'h0000, 16'h0000, 16'h0000, 16'h0000}
    };
    logic [7:0] dir_e [5] = '{8'h01, 8'h00, 8'hF9, 8'h01, 8'h80};
    logic [7:0] dir_m [5][BS] = '{
        '{8'h40, 8'hC0, 8'h20, 8'h00},
        '{8'h80, 8'h00, 8'h00, 8'h00},
        '{8'h40, 8'h00, 8'h00, 8'h00},
        '{8'h40, 8'hBF, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00}
    };

    always #5 clk = ~clk;

    fixed_to_mxint #(
        .IN_WIDTH      (16),
        .IN_FRAC_WIDTH (8),
        .OUT_MAN_WIDTH (8),
        .OUT_EXP_WIDTH (8),
        .BLOCK_SIZE    (BS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .mdata_out      (mdata_out),
        .edata_out      (edata_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    // Reference: E is the smallest exponent with |x| < 2^E for all elements
    // (clamped at -128), M = floor(x_real * 2^(7-E)) with x_real = x / 256.
    function automatic void model(input logic [15:0] x [BS], output exp_t r);
        int xv, mag, mx, p, e, n, d, q;
        mx = 0;
        for (int i = 0; i < BS; i++) begin
            xv  = int'($signed(x[i]));
            mag = (xv < 0) ? (-xv - 1) : xv;
            if (mag > mx) mx = mag;
        end
        r = '0;
        if (mx == 0) begin
            r.e = 8'h80;
        end else begin
            p = 0;
            while ((1 << (p + 1)) <= mx) p++;
            e = p - 7;
            if (e < -128) e = -128;
            n = e + 1;
            for (int i = 0; i < BS; i++) begin
                xv = int'($signed(x[i]));
                if (n >= 0) begin
                    d = 1 << n;
                    q = xv / d;
                    if ((xv % d != 0) && (xv < 0)) q = q - 1;
                end else begin
                    q = xv * (1 << (-n));
                end
                r.m[i] = q[7:0];
            end
            r.e = e[7:0];
        end
    endfunction

    function automatic void gen_block(output logic [15:0] b [BS]);
        int r;
        logic [15:0] t;
        bit zero_blk;
        zero_blk = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < BS; i++) begin
            t = 16'($urandom);
            r = int'($signed(t));
            r = r >>> $urandom_range(0, 15);
            b[i] = zero_blk ? 16'h0000 : r[15:0];
        end
    endfunction

    task automatic drive_garbage();
        for (int i = 0; i < BS; i++) data_in[i] = 16'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        data_in_valid = 1'b0;
        data_out_ready = 1'b1;
        drive_garbage();
        #2;
        nassert++;
        if (data_out_valid !== 1'b0) begin
            nfail++; $display("FAIL reset_valid: got %b expected 0", data_out_valid);
        end
        nassert++;
        if (edata_out !== 8'h00) begin
            nfail++; $display("FAIL reset_edata: got %h expected 00", edata_out);
        end
        for (int i = 0; i < BS; i++) begin
            nassert++;
            if (mdata_out[i] !== 8'h00) begin
                nfail++; $display("FAIL reset_mdata[%0d]: got %h expected 00", i, mdata_out[i]);
            end
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        nassert++;
        if (data_in_ready !== 1'b1) begin
            nfail++; $display("FAIL reset_ready: got %b expected 1", data_in_ready);
        end
    endtask

    task automatic test_directed();
        for (int v = 0; v < 5; v++) begin
            @(posedge clk); #1;
            data_in = dir_in[v];
            data_in_valid = 1'b1;
            data_out_ready = 1'b1;
            @(posedge clk); #1;
            data_in_valid = 1'b0;
            drive_garbage();
            nassert++;
            if (data_out_valid !== 1'b0) begin
                nfail++; $display("FAIL dir%0d_early_valid: got %b expected 0", v, data_out_valid);
            end
            @(posedge clk); #1;
            nassert++;
            if (data_out_valid !== 1'b1) begin
                nfail++; $display("FAIL dir%0d_valid: got %b expected 1", v, data_out_valid);
            end
            nassert++;
            if (edata_out !== dir_e[v]) begin
                nfail++; $display("FAIL dir%0d_edata: got %h expected %h", v, edata_out, dir_e[v]);
            end
            for (int i = 0; i < BS; i++) begin
                nassert++;
                if (mdata_out[i] !== dir_m[v][i]) begin
                    nfail++;
                    $display("FAIL dir%0d_mdata[%0d]: got %h expected %h", v, i, mdata_out[i], dir_m[v][i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] blks [4][BS];
        exp_t ex [4];
        for (int k = 0; k < 4; k++) begin
            gen_block(blks[k]);
            model(blks[k], ex[k]);
        end
        data_out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c < 4) begin
                data_in = blks[c];
                data_in_valid = 1'b1;
            end else begin
                data_in_valid = 1'b0;
                drive_garbage();
            end
            #2;
            nassert++;
            if (data_in_ready !== 1'b1) begin
                nfail++; $display("FAIL b2b_ready c%0d: got %b expected 1", c, data_in_ready);
            end
            nassert++;
            if (data_out_valid !== (c >= 2)) begin
                nfail++; $display("FAIL b2b_valid c%0d: got %b expected %b", c, data_out_valid, c >= 2);
            end
            if (c >= 2) begin
                nassert++;
                if (edata_out !== ex[c-2].e) begin
                    nfail++; $display("FAIL b2b_edata c%0d: got %h expected %h", c, edata_out, ex[c-2].e);
                end
                for (int i = 0; i < BS; i++) begin
                    nassert++;
                    if (mdata_out[i] !== ex[c-2].m[i]) begin
                        nfail++;
                        $display("FAIL b2b_mdata c%0d[%0d]: got %h expected %h", c, i, mdata_out[i], ex[c-2].m[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_random_stream();
        exp_t        sb [$];
        exp_t        ex;
        logic [15:0] blk [BS];
        logic [7:0]  held_e;
        logic [7:0]  held_m [BS];
        int sent = 0, got = 0, occ = 0, cyc = 0;
        bit prev_stall = 1'b0;
        bit acc, emit;
        gen_block(blk);
        while (got < 10 && cyc < 500) begin
            @(posedge clk); #1;
            data_out_ready = 1'($urandom_range(0, 1));
            if (sent < 10 && $urandom_range(0, 3) != 0) begin
                data_in_valid = 1'b1;
                data_in = blk;
            end else begin
                data_in_valid = 1'b0;
                drive_garbage();
            end
            #2;
            if (prev_stall) begin
                nassert++;
                if (data_out_valid !== 1'b1 || edata_out !== held_e) begin
                    nfail++;
                    $display("FAIL stall_hold_e: got v=%b e=%h expected v=1 e=%h", data_out_valid, edata_out, held_e);
                end
                for (int i = 0; i < BS; i++) begin
                    nassert++;
                    if (mdata_out[i] !== held_m[i]) begin
                        nfail++; $display("FAIL stall_hold_m[%0d]: got %h expected %h", i, mdata_out[i], held_m[i]);
                    end
                end
            end
            nassert++;
            if (data_in_ready !== ((occ < 2) || data_out_ready)) begin
                nfail++;
                $display("FAIL stream_ready: got %b expected %b (held %0d)", data_in_ready, (occ < 2) || data_out_ready, occ);
            end
            acc  = data_in_valid && data_in_ready;
            emit = data_out_valid && data_out_ready;
            if (emit) begin
                nassert++;
                if (sb.size() == 0) begin
                    nfail++; $display("FAIL stream_spurious: got valid block expected none");
                end else begin
                    ex = sb.pop_front();
                    if (edata_out !== ex.e) begin
                        nfail++; $display("FAIL stream_edata blk%0d: got %h expected %h", got, edata_out, ex.e);
                    end
                    for (int i = 0; i < BS; i++) begin
                        nassert++;
                        if (mdata_out[i] !== ex.m[i]) begin
                            nfail++;
                            $display("FAIL stream_mdata blk%0d[%0d]: got %h expected %h", got, i, mdata_out[i], ex.m[i]);
                        end
                    end
                end
                got++;
            end
            if (acc) begin
                model(blk, ex);
                sb.push_back(ex);
                sent++;
                gen_block(blk);
            end
            prev_stall = data_out_valid && !data_out_ready;
            held_e = edata_out;
            held_m = mdata_out;
            occ = occ + int'(acc) - int'(emit);
            cyc++;
        end
        nassert++;
        if (got != 10) begin
            nfail++; $display("FAIL stream_timeout: got %0d blocks expected 10", got);
        end
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_midstream();
        logic [15:0] blk [BS];
        @(posedge clk); #1;
        data_out_ready = 1'b0;
        gen_block(blk);
        data_in = blk;
        data_in_valid = 1'b1;
        @(posedge clk); #1;
        gen_block(blk);
        data_in = blk;
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        #1;
        nassert++;
        if (data_in_ready !== 1'b0 || data_out_valid !== 1'b1) begin
            nfail++;
            $display("FAIL full_refuse: got ready=%b valid=%b expected ready=0 valid=1", data_in_ready, data_out_valid);
        end
        rst = 1'b0;
        #1;
        nassert++;
        if (data_out_valid !== 1'b0 || edata_out !== 8'h00) begin
            nfail++;
            $display("FAIL midrst_out: got valid=%b e=%h expected valid=0 e=00", data_out_valid, edata_out);
        end
        for (int i = 0; i < BS; i++) begin
            nassert++;
            if (mdata_out[i] !== 8'h00) begin
                nfail++; $display("FAIL midrst_mdata[%0d]: got %h expected 00", i, mdata_out[i]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        data_out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            nassert++;
            if (data_out_valid !== 1'b0) begin
                nfail++; $display("FAIL midrst_stale c%0d: got valid=%b expected 0", c, data_out_valid);
            end
        end
        data_in = dir_in[0];
        data_in_valid = 1'b1;
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        @(posedge clk); #1;
        nassert++;
        if (data_out_valid !== 1'b1 || edata_out !== 8'h01 || mdata_out[1] !== 8'hC0) begin
            nfail++;
            $display("FAIL post_rst_block: got v=%b e=%h m1=%h expected v=1 e=01 m1=c0", data_out_valid, edata_out, mdata_out[1]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_stream();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
